// File: rtl/memb_drain.sv
// memb_drain: readout stage for MemoryB.
//
// When the Controller is idle and start is pulsed, this block walks MemoryB
// addresses 0..DEPTH-1. It streams each word out over a valid/ready handshake
// and accumulates an unsigned sum and maximum of the drained words.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset; clears all state immediately
//   start      one-cycle drain request, sampled only while idle
//   rd_addr    MemoryB address (MemoryB read is combinational)
//   rd_data    MemoryB read data
//   out_data   streamed word (registered)
//   out_valid  out_data holds a word that has not been accepted yet
//   out_ready  consumer accepts the word this cycle
//   out_last   out_data is entry DEPTH-1
//   busy       high in any state other than idle
//   done       one-cycle pulse after the last word is accepted
//   sum_out    unsigned sum of the drained words, held until the next start
//   max_out    unsigned maximum of the drained words, held until the next start
module memb_drain #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W+ADDR_W-1:0] sum_out,
  output logic [DATA_W-1:0]        max_out
);

  localparam int unsigned SumW = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StSummary
  } state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [DATA_W-1:0] dataQ, dataD;
  logic              validQ, validD;
  logic              lastQ, lastD;
  logic [SumW-1:0]   sumQ, sumD;
  logic [DATA_W-1:0] maxQ, maxD;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ <= StIdle;
      addrQ  <= '0;
      dataQ  <= '0;
      validQ <= 1'b0;
      lastQ  <= 1'b0;
      sumQ   <= '0;
      maxQ   <= '0;
    end else begin
      stateQ <= stateD;
      addrQ  <= addrD;
      dataQ  <= dataD;
      validQ <= validD;
      lastQ  <= lastD;
      sumQ   <= sumD;
      maxQ   <= maxD;
    end
  end

  always_comb begin
    stateD = stateQ;
    addrD  = addrQ;
    dataD  = dataQ;
    validD = validQ;
    lastD  = lastQ;
    sumD   = sumQ;
    maxD   = maxQ;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          // Results of the previous run are held until a new run begins.
          sumD   = '0;
          maxD   = '0;
          stateD = StLoad;
        end
      end

      StLoad: begin
        dataD  = rd_data;
        validD = 1'b1;
        lastD  = (addrQ == LastAddr);
        sumD   = sumQ + SumW'(rd_data);
        if (rd_data > maxQ) begin
          maxD = rd_data;
        end
        stateD = StSend;
      end

      StSend: begin
        if (out_ready) begin
          validD = 1'b0;
          lastD  = 1'b0;
          if (lastQ) begin
            stateD = StSummary;
          end else begin
            addrD  = addrQ + 1'b1;
            stateD = StLoad;
          end
        end
      end

      StSummary: begin
        addrD  = '0;
        stateD = StIdle;
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  assign rd_addr   = addrQ;
  assign out_data  = dataQ;
  assign out_valid = validQ;
  assign out_last  = lastQ;
  assign busy      = (stateQ != StIdle);
  assign done      = (stateQ == StSummary);
  assign sum_out   = sumQ;
  assign max_out   = maxQ;

endmodule

// File: tb/tb_memb_drain.sv
// Self-checking bench for memb_drain: directed scenarios followed by random
// data with random backpressure, checked against a table-level model.
module tb_memb_drain;

  localparam int Depth = 4;

  localparam int MNormal = 0;
  localparam int MBack   = 1;
  localparam int MInject = 2;
  localparam int MReset  = 3;
  localparam int MRandom = 4;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;
  logic [9:0] sum_out;
  logic [7:0] max_out;

  logic [7:0] mem [Depth];

  int testsRun    = 0;
  int testsFailed = 0;
  int doneAt;

  assign rd_data = mem[rd_addr];

  memb_drain dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .max_out   (max_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, " rd_addr"}, 32'(rd_addr), 0);
    check({tag, " out_data"}, 32'(out_data), 0);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " out_last"}, 32'(out_last), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " sum_out"}, 32'(sum_out), 0);
    check({tag, " max_out"}, 32'(max_out), 0);
  endtask

  task automatic loadMem(input int a, input int b, input int c, input int d);
    mem[0] = 8'(a);
    mem[1] = 8'(b);
    mem[2] = 8'(c);
    mem[3] = 8'(d);
  endtask

  // Called just after a falling edge; start is sampled at the next rising
  // edge E0. Iteration j runs just after the falling edge following E_j.
  task automatic runDrain(input int mode, output int doneSeen);
    int         idx       = 0;
    int         stalls    = 0;
    int         j         = -1;
    int         doneCnt   = 0;
    int         bpLeft    = 3;
    int         expSum    = 0;
    int         expMax    = 0;
    bit         finished  = 0;
    bit         prevStall = 0;
    bit         ready;
    logic [7:0] prevData  = '0;
    logic       prevLast  = 1'b0;

    for (int i = 0; i < Depth; i++) begin
      expSum += int'(mem[i]);
      if (int'(mem[i]) > expMax) expMax = int'(mem[i]);
    end
    doneSeen = -1;
    start    = 1'b1;

    while (!finished) begin
      @(negedge clock);
      j++;
      start = 1'b0;

      if (j == 0) begin
        check("start busy", 32'(busy), 1);
        check("start valid", 32'(out_valid), 0);
        check("start sum cleared", 32'(sum_out), 0);
        check("start max cleared", 32'(max_out), 0);
      end

      if (prevStall) begin
        check("hold valid", 32'(out_valid), 1);
        check("hold data", 32'(out_data), 32'(prevData));
        check("hold last", 32'(out_last), 32'(prevLast));
      end

      if (mode == MReset && out_valid && idx == 2) begin
        reset = 1'b0;
        #1;
        checkIdle("async reset");
        @(negedge clock);
        reset = 1'b1;
        checkIdle("reset held");
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          check("post reset done", 32'(done), 0);
          check("post reset busy", 32'(busy), 0);
        end
        return;
      end

      if (done) begin
        doneCnt++;
        if (doneSeen < 0) doneSeen = j;
        check("done timing", 32'(j), 32'(2 * Depth + stalls));
        check("sum at done", 32'(sum_out), 32'(expSum));
        check("max at done", 32'(max_out), 32'(expMax));
      end

      if (doneSeen >= 0 && j == doneSeen + 1) begin
        check("end busy", 32'(busy), 0);
        check("end done", 32'(done), 0);
        check("end valid", 32'(out_valid), 0);
        check("done count", 32'(doneCnt), 1);
        check("words sent", 32'(idx), 32'(Depth));
        check("sum held", 32'(sum_out), 32'(expSum));
        check("max held", 32'(max_out), 32'(expMax));
        finished = 1;
      end

      if (mode == MBack) begin
        ready = !(out_valid && idx == 1 && bpLeft > 0);
        if (!ready) bpLeft--;
      end else if (mode == MRandom) begin
        ready = ($urandom_range(0, 1) == 1);
      end else begin
        ready = 1'b1;
      end
      out_ready = ready;

      if (mode == MInject && !finished && (j == 3 || done)) start = 1'b1;

      prevStall = out_valid && !ready;
      if (prevStall) stalls++;
      prevData = out_data;
      prevLast = out_last;

      if (out_valid && ready) begin
        if (idx < Depth) begin
          check("word data", 32'(out_data), 32'(mem[idx]));
          check("word last", 32'(out_last), 32'(idx == Depth - 1));
          check("word addr", 32'(rd_addr), 32'(idx));
        end else begin
          check("extra word", 32'(idx), 32'(Depth - 1));
        end
        idx++;
      end

      if (j > 400 && !finished) begin
        check("cycle budget", 32'(j), 400);
        finished = 1;
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    loadMem(0, 0, 0, 0);
    #1;
    checkIdle("reset");
    #20;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkIdle("after reset");

    loadMem(3, 250, 7, 8'h80);
    runDrain(MNormal, doneAt);
    check("basic done cycle", 32'(doneAt), 8);
    check("basic sum", 32'(sum_out), 388);
    check("basic max", 32'(max_out), 250);

    runDrain(MBack, doneAt);
    check("backpressure done cycle", 32'(doneAt), 11);

    loadMem(255, 255, 255, 255);
    runDrain(MNormal, doneAt);
    check("ff sum", 32'(sum_out), 1020);
    check("ff max", 32'(max_out), 255);

    loadMem(0, 0, 0, 0);
    runDrain(MNormal, doneAt);
    check("zero sum", 32'(sum_out), 0);
    check("zero max", 32'(max_out), 0);

    loadMem(3, 250, 7, 8'h80);
    runDrain(MInject, doneAt);
    check("inject done cycle", 32'(doneAt), 8);
    check("inject sum", 32'(sum_out), 388);

    // Back-to-back: next start goes out right after done clears.
    loadMem(1, 2, 3, 4);
    runDrain(MNormal, doneAt);
    check("b2b sum", 32'(sum_out), 10);
    check("b2b max", 32'(max_out), 4);

    loadMem(9, 8, 7, 6);
    runDrain(MReset, doneAt);
    runDrain(MNormal, doneAt);
    check("restart sum", 32'(sum_out), 30);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < Depth; i++) mem[i] = 8'($urandom_range(0, 255));
      runDrain(MRandom, doneAt);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/memb_drain.md
# memb_drain

Downstream readout stage for MemoryB: after the Controller finishes writing the 4-entry difference/sum table, this block walks MemoryB addresses 0..DEPTH-1, streams each word out over a valid/ready handshake, and accumulates an unsigned sum and maximum of the table. It drives MemoryB's address input while the Controller is idle and presents the stream and the summary results to the next consumer.

## Interface
- DATA_W, 8, width of a MemoryB word
- ADDR_W, 2, MemoryB address width
- DEPTH, 4, number of entries drained per run (DEPTH <= 2^ADDR_W)

- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  one-cycle request to drain MemoryB; sampled only in IDLE
- rd_addr  out  ADDR_W  address to MemoryB (combinational read, data valid in the same cycle)
- rd_data  in  DATA_W  MemoryB dataOutB
- out_data  out  DATA_W  current streamed word (registered)
- out_valid  out  1  out_data holds a word not yet accepted
- out_ready  in  1  consumer can accept a word this cycle
- out_last  out  1  qualifies out_data as entry DEPTH-1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- sum_out  out  DATA_W+ADDR_W  unsigned sum of all drained words (held until next start)
- max_out  out  DATA_W  unsigned maximum of all drained words (held until next start)

## Operation
- States: IDLE, LOAD, SEND, SUMMARY.
- IDLE: rd_addr=0. start=1 at an edge -> LOAD; same edge clears sum_out and max_out to 0.
- LOAD: at the edge, out_data<=rd_data, out_valid<=1, out_last<=(rd_addr==DEPTH-1), sum_out<=sum_out+rd_data (zero-extended), max_out<=rd_data if rd_data>max_out (unsigned), -> SEND.
- SEND: out_data/out_valid/out_last held stable. At an edge with out_ready=1 (transfer): out_valid<=0, out_last<=0; if out_last was 1 -> SUMMARY, else rd_addr<=rd_addr+1 -> LOAD. out_ready=0: remain in SEND indefinitely.
- SUMMARY: done=1 (Moore output, this state only); rd_addr<=0 -> IDLE at next edge.
- start ignored in LOAD, SEND, SUMMARY (no queuing, no restart).
- out_ready while out_valid=0 has no effect.
- Arithmetic: words are unsigned (MemoryB holds mod-256 add/sub results); sum width DATA_W+ADDR_W cannot overflow for DEPTH<=4; max compare unsigned.
- rd_addr increments only on non-last transfer; never wraps within a run.
- Reset (reset=0) at any time, including mid-stream: state IDLE, all outputs 0 immediately; a partially drained run is abandoned, no done pulse.

## Timing
- Reset values: rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, sum_out=0, max_out=0.
- start sampled at edge E0 -> busy high after E0; first out_valid high after E1.
- Per word minimum 2 cycles (LOAD + SEND) with out_ready held 1: words valid after E1, E3, E5, E7; last transfer at E8; done high E8..E9; busy low after E9.
- Each cycle of out_ready=0 in SEND adds exactly one cycle.
- sum_out/max_out final value visible after the LOAD of the last word (E7) and stable through and after done.
- rd_data must be stable during LOAD; the Controller must not write MemoryB while busy=1.

## Test plan
- Reset: drive reset=0 mid-run (in SEND at word 2) -> all outputs 0 asynchronously; after release no done, IDLE, start restarts from address 0.
- Basic drain: MemoryB={3, 250, 7, 0x80}, start pulse, out_ready=1 -> out_data 3,250,7,0x80 in order, out_last only on 0x80, done one cycle after E8, sum_out=388 (0x184), max_out=250.
- Backpressure: same data, out_ready=0 for 3 cycles on word 1 -> out_data=250 and out_valid held stable all 3 cycles, no duplication/loss, done delayed by exactly 3 cycles.
- Extremes: MemoryB={0xFF,0xFF,0xFF,0xFF} -> sum_out=1020 (0x3FC), max_out=255; all-zero -> sum_out=0, max_out=0.
- Start while busy: pulse start during SEND of word 1 and during SUMMARY -> ignored; single done, results unchanged.
- Back-to-back runs: start the cycle after done clears with new data {1,2,3,4} -> sum_out cleared then ends at 10, max_out=4.
